reg8_write_arbiter: RTL and testbench

Round-robin arbiter and write sequencer that shares one 8-bit enable-loaded register (en/d/q style) between N requesters.
- Grants one requester at a time.
- Drives the register's load-enable and data for exactly one cycle.
- Returns a registered acknowledge.
- Holds ownership until the winner drops its request.
- Sits between bus masters and a shared datapath register; the register's q output is read directly by consumers.

---
 rtl/reg8_write_arbiter.sv | 140 ++++++++++++++
 tb/tb_reg8_write_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg8_write_arbiter.sv
// reg8_write_arbiter: round-robin arbiter and single-cycle write sequencer
// that shares one enable-loaded register between N_REQ requesters.
// Optional build macro ARB_WCOUNT_EN adds the committed-write counter
// (wcount) and the last_owner output.
module reg8_write_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int ID_W   = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    output logic                    reg_en,
    output logic [DATA_W-1:0]       reg_d,
    output logic [ID_W-1:0]         owner,
    output logic                    busy
`ifdef ARB_WCOUNT_EN
    ,
    output logic [15:0]             wcount,
    output logic [ID_W-1:0]         last_owner
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [ID_W-1:0]     ptr, ptr_nxt;
    logic [ID_W-1:0]     owner_nxt;
    logic [N_REQ-1:0]    gnt_nxt, ack_nxt;
    logic                reg_en_nxt, busy_nxt;
    logic [DATA_W-1:0]   reg_d_nxt;
    logic                win_found;
    logic [ID_W-1:0]     win_idx;

    // Round-robin search: first requesting index at or above ptr, wrapping.
    always_comb begin : win_search
        int idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = ID_W'(idx);
            end
        end
    end

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        owner_nxt  = owner;
        gnt_nxt    = gnt;
        ack_nxt    = '0;
        reg_en_nxt = 1'b0;
        reg_d_nxt  = reg_d;
        busy_nxt   = busy;
        case (state)
            IDLE: begin
                gnt_nxt  = '0;
                busy_nxt = 1'b0;
                if (win_found) begin
                    gnt_nxt[win_idx] = 1'b1;
                    owner_nxt        = win_idx;
                    reg_d_nxt        = wdata[win_idx*DATA_W +: DATA_W];
                    reg_en_nxt       = 1'b1;
                    busy_nxt         = 1'b1;
                    state_nxt        = WRITE;
                end
            end
            WRITE: begin
                // The register loads on this edge; acknowledge the grant holder.
                ack_nxt   = gnt;
                state_nxt = RELEASE;
            end
            RELEASE: begin
                // No preemption: hold ownership until the owner lets go.
                if (!req[owner]) begin
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    owner_nxt = '0;
                    ptr_nxt   = (owner == ID_W'(N_REQ - 1)) ? '0 : owner + ID_W'(1);
                    state_nxt = IDLE;
                end
            end
            default: begin
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any write in progress.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            ptr    <= '0;
            owner  <= '0;
            gnt    <= '0;
            ack    <= '0;
            reg_en <= 1'b0;
            reg_d  <= '0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            owner  <= owner_nxt;
            gnt    <= gnt_nxt;
            ack    <= ack_nxt;
            reg_en <= reg_en_nxt;
            reg_d  <= reg_d_nxt;
            busy   <= busy_nxt;
        end
    end

`ifdef ARB_WCOUNT_EN
    // Committed-write counter (saturating) and owner of the latest write.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wcount     <= '0;
            last_owner <= '0;
        end else if (state == WRITE) begin
            if (wcount != 16'hFFFF) wcount <= wcount + 16'd1;
            last_owner <= owner;
        end
    end
`endif

endmodule

// File: tb/tb_reg8_write_arbiter.sv
// Directed testbench for reg8_write_arbiter, including a model of the
// shared enable-loaded register that the arbiter writes.
module tb_reg8_write_arbiter;

    logic        clk;
    logic        rstn;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic        reg_en;
    logic [7:0]  reg_d;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  q;
    logic        done;
`ifdef ARB_WCOUNT_EN
    logic [15:0] wcount;
    logic [1:0]  last_owner;
`endif

    int n_checks;
    int n_fail;

    reg8_write_arbiter #(.N_REQ(4), .DATA_W(8), .ID_W(2)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .req    (req),
        .wdata  (wdata),
        .gnt    (gnt),
        .ack    (ack),
        .reg_en (reg_en),
        .reg_d  (reg_d),
        .owner  (owner),
        .busy   (busy)
`ifdef ARB_WCOUNT_EN
        ,
        .wcount     (wcount),
        .last_owner (last_owner)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared register driven by the arbiter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) q <= 8'h00;
        else if (reg_en) q <= reg_d;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_en(input string tag);
        int i;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!reg_en && i < 20);
        check(tag, 32'(reg_en), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        req  = '0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Exclusivity: gnt and ack are never more than one-hot.
    always @(negedge clk) begin
        if (rstn && !done) begin
            check("gnt_ack_onehot",
                  32'(($countones(gnt) <= 1) && ($countones(ack) <= 1)), 32'd1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rr_data [4];
        int prev;
        int e;
        n_checks = 0;
        n_fail   = 0;
        done     = 1'b0;
        rstn     = 1'b0;
        req      = '0;
        wdata    = '0;
        #12 rstn = 1'b1;

        // Reset state held for 5 idle cycles
        repeat (5) begin
            @(negedge clk);
            check("rst_gnt", 32'(gnt), 32'h0);
            check("rst_ack", 32'(ack), 32'h0);
            check("rst_reg_en", 32'(reg_en), 32'h0);
            check("rst_reg_d", 32'(reg_d), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
            check("rst_q", 32'(q), 32'h0);
        end

        // Single write by requester 2
        req = 4'b0100;
        wdata[16 +: 8] = 8'hA5;
        @(negedge clk);
        check("sw_gnt", 32'(gnt), 32'h4);
        check("sw_reg_en", 32'(reg_en), 32'h1);
        check("sw_reg_d", 32'(reg_d), 32'hA5);
        check("sw_owner", 32'(owner), 32'h2);
        check("sw_busy", 32'(busy), 32'h1);
        check("sw_ack_early", 32'(ack), 32'h0);
        @(negedge clk);
        check("sw_reg_en_off", 32'(reg_en), 32'h0);
        check("sw_ack", 32'(ack), 32'h4);
        check("sw_q", 32'(q), 32'hA5);
        req = 4'b0000;
        @(negedge clk);
        check("sw_gnt_rel", 32'(gnt), 32'h0);
        check("sw_busy_rel", 32'(busy), 32'h0);
        check("sw_ack_rel", 32'(ack), 32'h0);

        // Round robin, starting from ptr = 0
        do_reset();
        rr_data[0] = 8'h11; rr_data[1] = 8'h22; rr_data[2] = 8'h33; rr_data[3] = 8'h44;
        wdata = 32'h44332211;
        req   = 4'b1111;
        prev  = -1;
        for (int k = 0; k < 5; k++) begin
            e = k % 4;
            wait_en("rr_en");
            if (prev >= 0) req[prev] = 1'b1;
            check("rr_owner", 32'(owner), 32'(e));
            check("rr_reg_d", 32'(reg_d), 32'(rr_data[e]));
            @(negedge clk);
            check("rr_ack", 32'(ack), 32'(1 << e));
            check("rr_q", 32'(q), 32'(rr_data[e]));
            req[e] = 1'b0;
            prev = e;
        end
`ifdef ARB_WCOUNT_EN
        check("rr_wcount", 32'(wcount), 32'd5);
        check("rr_last_owner", 32'(last_owner), 32'd0);
`endif
        req = 4'b0000;
        @(negedge clk);

        // No preemption: requester 1 holds, requester 3 waits (ptr = 1)
        wdata[8 +: 8]  = 8'h5A;
        wdata[24 +: 8] = 8'h3C;
        req = 4'b1010;
        wait_en("np_en1");
        check("np_owner1", 32'(owner), 32'd1);
        check("np_reg_d1", 32'(reg_d), 32'h5A);
        @(negedge clk);
        check("np_ack1", 32'(ack), 32'h2);
        check("np_q1", 32'(q), 32'h5A);
        repeat (6) begin
            @(negedge clk);
            check("np_hold_en", 32'(reg_en), 32'h0);
            check("np_hold_gnt", 32'(gnt), 32'h2);
            check("np_hold_q", 32'(q), 32'h5A);
        end
        req[1] = 1'b0;
        wait_en("np_en3");
        check("np_owner3", 32'(owner), 32'd3);
        check("np_reg_d3", 32'(reg_d), 32'h3C);
        @(negedge clk);
        check("np_ack3", 32'(ack), 32'h8);
        check("np_q3", 32'(q), 32'h3C);
        req = 4'b0000;
        @(negedge clk);

        // Data stability: wdata changes after the grant edge are ignored (ptr = 0)
        req = 4'b0001;
        wdata[7:0] = 8'hFF;
        wait_en("ds_en");
        check("ds_reg_d", 32'(reg_d), 32'hFF);
        wdata[7:0] = 8'h00;
        @(negedge clk);
        check("ds_ack", 32'(ack), 32'h1);
        check("ds_q", 32'(q), 32'hFF);
        @(negedge clk);
        check("ds_q_hold", 32'(q), 32'hFF);
        check("ds_ack_pulse", 32'(ack), 32'h0);
        req = 4'b0000;
        @(negedge clk);
        check("ds_busy", 32'(busy), 32'h0);
        check("ds_q_idle", 32'(q), 32'hFF);

        // Requester 2 write moves ptr to 3
        req = 4'b0100;
        wdata[16 +: 8] = 8'h77;
        wait_en("pre_en2");
        check("pre_owner2", 32'(owner), 32'd2);
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);

        // Reset mid-write during requester 3's WRITE cycle
        req = 4'b1000;
        wdata[24 +: 8] = 8'h99;
        wait_en("mr_en3");
        check("mr_owner3", 32'(owner), 32'd3);
        rstn = 1'b0;
        #1;
        check("mr_gnt", 32'(gnt), 32'h0);
        check("mr_ack", 32'(ack), 32'h0);
        check("mr_reg_en", 32'(reg_en), 32'h0);
        check("mr_busy", 32'(busy), 32'h0);
`ifdef ARB_WCOUNT_EN
        check("mr_wcount", 32'(wcount), 32'd0);
`endif
        req = 4'b1010;
        @(negedge clk);
        check("mr_no_ack", 32'(ack), 32'h0);
        rstn = 1'b1;
        wait_en("mr_en_after");
        check("mr_owner_after", 32'(owner), 32'd1);
        check("mr_gnt_after", 32'(gnt), 32'h2);
        @(negedge clk);
        check("mr_ack_after", 32'(ack), 32'h2);
        check("mr_q_after", 32'(q), 32'h5A);
        req = 4'b0000;
        @(negedge clk);
        done = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
